// File: rtl/maple_rx_framer.sv
// Maple Bus receive frame controller: packs decoded bytes into AXI4-Stream
// beats (lane 0 = first byte), terminates frames with TLAST/partial TKEEP,
// checks the XOR CRC, bounds frame length and reports per-frame status.
module maple_rx_framer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_MAX_BYTES          = 1028,
  parameter int C_LEN_WIDTH          = 11
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              START_EVT,
  input  logic                              START_CRC,
  input  logic                              END_EVT,
  input  logic                              END_ERR,
  input  logic [7:0]                        S_TDATA,
  input  logic                              S_TVALID,
  output logic                              DEC_ENABLE,
  input  logic                              ENABLE,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              RECEIVING,
  output logic                              FRAME_DONE,
  output logic [3:0]                        FRAME_STATUS,
  output logic [C_LEN_WIDTH-1:0]            FRAME_BYTES
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int K  = W / 8;
  localparam int KB = (K > 1) ? $clog2(K) : 1;
  localparam logic [C_LEN_WIDTH-1:0] K_L   = C_LEN_WIDTH'(K);
  localparam logic [C_LEN_WIDTH-1:0] MAX_L = C_LEN_WIDTH'(C_MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_ENABLED, S_SKIP, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic [W-1:0]             acc, pend, acc_wr;
  logic                     pend_valid;
  logic [C_LEN_WIDTH-1:0]   byte_cnt;
  logic [7:0]               crc;
  logic                     crc_en, aborted, ovf, end_err_r;
  logic                     flush_end, restart_go, restart_crc, frame_ok;

  logic                     go_en, end_any, out_free, have_last, flush_ready;
  logic                     byte_in, store, push, fill, load_push, load_flush;
  logic [KB-1:0]            lane;
  logic [K-1:0]             last_keep;

  assign go_en       = ENABLE & M_AXIS_TREADY;
  assign end_any     = END_EVT | END_ERR;
  assign lane        = KB'(byte_cnt % K_L);
  assign out_free    = ~M_AXIS_TVALID | M_AXIS_TREADY;
  assign have_last   = (lane != '0) | pend_valid;
  assign flush_ready = ~have_last | out_free;
  assign byte_in     = (state == S_ENABLED) & S_TVALID;
  assign store       = byte_in & (byte_cnt < MAX_L);
  assign push        = store & (lane == '0) & pend_valid;
  assign fill        = store & (lane == KB'(K - 1));
  assign load_push   = push & out_free;
  assign load_flush  = (state == S_FLUSH) & have_last & out_free;
  assign M_AXIS_TSTRB = M_AXIS_TKEEP;

  // Accumulator write image and partial-beat keep mask
  always_comb begin
    acc_wr    = (lane == '0) ? '0 : acc;
    last_keep = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (lane == KB'(i)) acc_wr[8*i +: 8] = S_TDATA;
      last_keep[i] = (i < 32'(lane));
    end
  end

  // State register
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) state <= S_IDLE;
    else                 state <= state_nxt;
  end

  // Next-state logic; an end event beats a simultaneous start
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (START_EVT) state_nxt = go_en ? S_ENABLED : S_SKIP;
      S_ENABLED: if (end_any || START_EVT) state_nxt = S_FLUSH;
      S_SKIP: begin
        if (end_any)                 state_nxt = S_DONE;
        else if (START_EVT && go_en) state_nxt = S_ENABLED;
      end
      S_FLUSH: if (flush_ready)
                 state_nxt = flush_end ? S_DONE : (restart_go ? S_ENABLED : S_SKIP);
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    DEC_ENABLE = (state == S_ENABLED);
    RECEIVING  = (state != S_IDLE);
  end

  // Byte packing, CRC, per-frame flags and status capture
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      acc <= '0; pend <= '0; pend_valid <= 1'b0; byte_cnt <= '0; crc <= '0;
      crc_en <= 1'b0; aborted <= 1'b0; ovf <= 1'b0; end_err_r <= 1'b0;
      flush_end <= 1'b0; restart_go <= 1'b0; restart_crc <= 1'b0; frame_ok <= 1'b0;
      FRAME_DONE <= 1'b0; FRAME_STATUS <= '0; FRAME_BYTES <= '0;
    end else begin
      FRAME_DONE <= (state == S_DONE) & frame_ok;
      if (state == S_DONE) frame_ok <= 1'b0;

      if ((state == S_IDLE || state == S_SKIP) && START_EVT && go_en && !end_any)
        crc_en <= START_CRC;

      if (byte_in) begin
        crc <= crc ^ S_TDATA;
        if (!store) ovf <= 1'b1;
      end
      if (store) begin
        acc      <= acc_wr;
        byte_cnt <= byte_cnt + C_LEN_WIDTH'(1);
        // With K=1 a word both pushes the old pending and refills it
        if (fill) begin
          pend       <= acc_wr;
          pend_valid <= 1'b1;
        end else if (push) begin
          pend_valid <= 1'b0;
        end
      end
      if (push && !out_free) ovf <= 1'b1;

      if (state == S_ENABLED) begin
        if (end_any) begin
          flush_end <= 1'b1;
          end_err_r <= END_ERR;
        end else if (START_EVT) begin
          flush_end   <= 1'b0;
          aborted     <= 1'b1;
          restart_go  <= go_en;
          restart_crc <= START_CRC;
        end
      end

      if (state == S_FLUSH && flush_ready) begin
        FRAME_STATUS <= {aborted, ovf, end_err_r, crc_en & (|crc)};
        FRAME_BYTES  <= byte_cnt;
        frame_ok     <= flush_end;
        crc_en       <= ~flush_end & restart_go & restart_crc;
        acc <= '0; pend_valid <= 1'b0; byte_cnt <= '0; crc <= '0;
        aborted <= 1'b0; ovf <= 1'b0; end_err_r <= 1'b0;
      end
    end
  end

  // Output register: holds a beat until TREADY, may reload on the transfer cycle
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
    end else if (load_push) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= pend;
      M_AXIS_TKEEP  <= '1;
      M_AXIS_TLAST  <= 1'b0;
    end else if (load_flush) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TDATA  <= (lane != '0) ? acc : pend;
      M_AXIS_TKEEP  <= (lane != '0) ? last_keep : '1;
      M_AXIS_TLAST  <= 1'b1;
    end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

endmodule
